mips_result_checker: RTL and testbench
======================================

Name: mips_result_checker

Overview:
- Self-checking consumer of the processor's 16-bit test_valueO observation port; the reading end of that interface.
- Holds a table of expected values, tracks every change of the observed value after start, and compares each change in order against the table.
- Reports pass/fail, mismatch count, first failing index/value, and a timeout.
- Sits beside the MIPS top in simulation benches and FPGA bring-up; drives pass/done to LEDs or a bench $stop.

Parameters:
- DATA_W, 16, width of the observed value and of table entries.
- DEPTH, 16, number of expected-table entries (power of 2).
- ADDR_W, 4, log2(DEPTH).
- TIMEOUT, 64, cycles without a value change before the check aborts (≥2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state except table contents.
- test_value  in  DATA_W  observed processor value (test_valueO).
- start  in  1  one-cycle pulse; begins a check run.
- exp_wr_en  in  1  table write strobe.
- exp_wr_addr  in  ADDR_W  table write address.
- exp_wr_data  in  DATA_W  table write data.
- exp_count  in  ADDR_W+1  number of entries to check (0..DEPTH); sampled at start.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  valid when done; 1 = all entries matched, no timeout.
- timeout  out  1  valid when done; run ended by TIMEOUT.
- mismatch_cnt  out  8  mismatches this run, saturates at 255.
- fail_index  out  ADDR_W  index of the first mismatch.
- fail_value  out  DATA_W  observed value at the first mismatch.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; index, timer and prev-value cleared; table RAM is not cleared. Reset mid-run aborts the run without asserting done.
- FSM states: IDLE, RUN, DONE.
- IDLE: exp_wr_en writes the table. start latches exp_count into cnt_q, prev <= test_value (baseline, not checked), idx <= 0, timer <= 0, mismatch_cnt <= 0, done <= 0. Moves to RUN next cycle; busy = 1 from that cycle.
- DONE: start restarts exactly as from IDLE and clears done/pass/timeout on the same edge.
- exp_count = 0 at start: RUN completes on its first cycle with pass = 1.
- RUN, each cycle:
  - Event when test_value != prev.
  - On an event: compare test_value to table[idx]. On mismatch, mismatch_cnt++ (saturating); if this is the first mismatch, fail_index <= idx and fail_value <= test_value. Then prev <= test_value, idx++, timer <= 0.
  - No event: timer++.
- Completion: when idx + 1 == cnt_q on an event, go to DONE next edge with done = 1, busy = 0, pass = (final mismatch_cnt == 0).
- Timeout: timer == TIMEOUT-1 with no event gives DONE, timeout = 1, pass = 0.
- Event and timeout on the same cycle: the event wins and the timer resets.
- Repeated identical values produce no event; the table must list only changes.
- Ignored inputs:
  - start while busy.
  - exp_wr_en outside IDLE/DONE.
  - exp_count > DEPTH is clamped to DEPTH.
- Latency: compare result is visible in mismatch_cnt one cycle after the event; done is asserted one cycle after the last event.

Optional Feature:
- Macro: MISMATCH_HALT_EN.
- Defined: first mismatch moves the FSM to DONE on the next edge with pass = 0, timeout = 0, mismatch_cnt = 1.
- Undefined: the run continues through mismatches to completion or timeout.

Test Plan:
- Load table {0x0005, 0x000A, 0x000F}, exp_count = 3, baseline 0x0000, drive changes 5 → A → F with 3-cycle gaps -> done = 1, pass = 1, mismatch_cnt = 0, busy low one cycle after the 0x000F event.
- Same table, drive 5 → 0x00AA → F -> pass = 0, mismatch_cnt = 1, fail_index = 1, fail_value = 0x00AA. With MISMATCH_HALT_EN: done the cycle after 0x00AA, index 2 never checked.
- exp_count = 3, drive only 5 then hold for 64 cycles -> timeout = 1, pass = 0, done exactly TIMEOUT cycles after the last event.
- exp_count = 0, pulse start -> done = 1, pass = 1 one cycle after entering RUN.
- Assert reset mid-run after one event, then start again -> outputs zero after reset, table preserved, second run passes.
- Pulse start while busy, and pulse exp_wr_en while busy -> no restart, table unchanged, run completes normally.

Source files
------------

// File: rtl/mips_result_checker.sv
// Purpose: compares each change of the processor's test_value against a preloaded table; optional MISMATCH_HALT_EN ends the run at the first mismatch.
// Latency: mismatch_cnt updates one cycle after an event; done rises one cycle after the last event, or TIMEOUT cycles after it on a timeout.
// Backpressure: none; start is ignored while busy and table writes are ignored during a run.
module mips_result_checker #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] test_value,
    input  logic              start,
    input  logic              exp_wr_en,
    input  logic [ADDR_W-1:0] exp_wr_addr,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [ADDR_W:0]   exp_count,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [7:0]        mismatch_cnt,
    output logic [ADDR_W-1:0] fail_index,
    output logic [DATA_W-1:0] fail_value
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int              TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] prev_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W:0]   cnt_q;
    logic [TMR_W-1:0]  timer_q;

    logic              start_ok;
    logic              event_hit;
    logic              match;
    logic              stop_now;
    logic [7:0]        mis_next;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W:0]   cnt_clamp;

    assign start_ok  = start && (state_q != ST_RUN);
    assign cnt_clamp = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
    assign event_hit = (test_value != prev_q);
    assign match     = (test_value == mem[idx_q]);
    assign mis_next  = (!match && (mismatch_cnt != 8'hFF)) ? mismatch_cnt + 8'd1 : mismatch_cnt;
    assign idx_inc   = {1'b0, idx_q} + (ADDR_W + 1)'(1);

`ifdef MISMATCH_HALT_EN
    assign stop_now = (idx_inc == cnt_q) || !match;
`else
    assign stop_now = (idx_inc == cnt_q);
`endif

    // Table RAM survives reset so a bench can reload only what changes.
    always_ff @(posedge clk) begin
        if (exp_wr_en && (state_q != ST_RUN)) begin
            mem[exp_wr_addr] <= exp_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            mismatch_cnt <= 8'd0;
            fail_index   <= '0;
            fail_value   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                    end else if (event_hit) begin
                        // An event always beats a coincident timeout.
                        mismatch_cnt <= mis_next;
                        if (!match && (mismatch_cnt == 8'd0)) begin
                            fail_index <= idx_q;
                            fail_value <= test_value;
                        end
                        prev_q  <= test_value;
                        idx_q   <= idx_inc[ADDR_W-1:0];
                        timer_q <= '0;
                        if (stop_now) begin
                            state_q <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (mis_next == 8'd0);
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_q <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    if (start_ok) begin
                        state_q      <= ST_RUN;
                        cnt_q        <= cnt_clamp;
                        prev_q       <= test_value;
                        idx_q        <= '0;
                        timer_q      <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                        mismatch_cnt <= 8'd0;
                        fail_index   <= '0;
                        fail_value   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_result_checker.sv
// Purpose: scoreboard bench for mips_result_checker; a small model predicts mismatch_cnt/done per driven value.
// Latency: expectations are popped one cycle after each drive, matching the checker's compare latency.
// Backpressure: none; inputs change on the falling edge and outputs are sampled there.
module tb_mips_result_checker;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 64;
`ifdef MISMATCH_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] test_value = '0;
    logic              start = 1'b0;
    logic              exp_wr_en = 1'b0;
    logic [ADDR_W-1:0] exp_wr_addr = '0;
    logic [DATA_W-1:0] exp_wr_data = '0;
    logic [ADDR_W:0]   exp_count = '0;
    logic              busy, done, pass, timeout;
    logic [7:0]        mismatch_cnt;
    logic [ADDR_W-1:0] fail_index;
    logic [DATA_W-1:0] fail_value;

    always #5 clk = ~clk;

    mips_result_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .test_value(test_value), .start(start),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .exp_count(exp_count), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .mismatch_cnt(mismatch_cnt), .fail_index(fail_index), .fail_value(fail_value)
    );

    typedef struct {
        int mis;
        int dn;
    } exp_t;

    exp_t              sb_q[$];
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] tbl_m [DEPTH];
    logic [DATA_W-1:0] prev_m;
    logic [DATA_W-1:0] fval_m;
    int                idx_m, cnt_m, mis_m, fidx_m;
    bit                run_m, done_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        exp_wr_en   = 1'b1;
        exp_wr_addr = ADDR_W'(a);
        exp_wr_data = d;
        @(negedge clk);
        exp_wr_en   = 1'b0;
        tbl_m[a]    = d;
    endtask

    task automatic do_start(input int cnt);
        start     = 1'b1;
        exp_count = (ADDR_W + 1)'(cnt);
        prev_m    = test_value;
        idx_m     = 0;
        mis_m     = 0;
        fidx_m    = 0;
        fval_m    = '0;
        cnt_m     = (cnt > DEPTH) ? DEPTH : cnt;
        run_m     = 1'b1;
        done_m    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
    endtask

    task automatic drive(input logic [DATA_W-1:0] v);
        exp_t e;
        test_value = v;
        if (run_m && (v != prev_m)) begin
            if (v != tbl_m[idx_m]) begin
                if (mis_m == 0) begin
                    fidx_m = idx_m;
                    fval_m = v;
                end
                if (mis_m < 255) mis_m++;
            end
            prev_m = v;
            idx_m++;
            if ((idx_m == cnt_m) || (HALT && (mis_m != 0))) begin
                run_m  = 1'b0;
                done_m = 1'b1;
            end
        end
        e.mis = mis_m;
        e.dn  = int'(done_m);
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("sb_mis", 32'(mismatch_cnt), 32'(e.mis));
        chk("sb_done", 32'(done), 32'(e.dn));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_tmo"}, 32'(timeout), 32'd0);
        chk({tag, "_mis"}, 32'(mismatch_cnt), 32'd0);
        chk({tag, "_fidx"}, 32'(fail_index), 32'd0);
        chk({tag, "_fval"}, 32'(fail_value), 32'd0);
    endtask

    initial begin
        int n;
        run_m  = 1'b0;
        done_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_zero("rst");

        wr(0, 16'h0005);
        wr(1, 16'h000A);
        wr(2, 16'h000F);
        for (int i = 3; i < DEPTH; i++) wr(i, 16'h0100 + 16'(i));

        // Clean run 5 -> A -> F with gaps.
        test_value = 16'h0000;
        do_start(3);
        drive(16'h0005); hold(2);
        drive(16'h000A); hold(2);
        drive(16'h000F);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_tmo", 32'(timeout), 32'd0);

        // Mismatch at index 1, restarted from DONE.
        do_start(3);
        chk("t2_pass_clr", 32'(pass), 32'd0);
        drive(16'h0005);
        drive(16'h00AA);
        chk("t2_fidx", 32'(fail_index), 32'(fidx_m));
        chk("t2_fval", 32'(fail_value), 32'(fval_m));
        drive(16'h000F);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_fval_end", 32'(fail_value), 32'h00AA);
        chk("t2_fidx_end", 32'(fail_index), 32'd1);

        // Timeout after a single event.
        do_start(3);
        drive(16'h0005);
        n = 0;
        while (!done && n < 3 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        run_m  = 1'b0;
        done_m = 1'b1;
        chk("t3_latency", 32'(n), 32'(TIMEOUT));
        chk("t3_tmo", 32'(timeout), 32'd1);
        chk("t3_pass", 32'(pass), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_mis", 32'(mismatch_cnt), 32'd0);

        // Empty run.
        do_start(0);
        @(negedge clk);
        run_m  = 1'b0;
        done_m = 1'b1;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_pass", 32'(pass), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // Oversized exp_count clamps to DEPTH: all 16 entries.
        test_value = 16'h0000;
        do_start(31);
        for (int i = 0; i < DEPTH; i++) drive(tbl_m[i]);
        chk("t5_pass", 32'(pass), 32'd1);

        // Reset mid-run, table preserved, second run passes.
        test_value = 16'h0000;
        do_start(3);
        drive(16'h0005);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        run_m  = 1'b0;
        done_m = 1'b0;
        mis_m  = 0;
        check_zero("mid");
        test_value = 16'h0000;
        do_start(3);
        drive(16'h0005);
        drive(16'h000A);
        drive(16'h000F);
        chk("t6_pass", 32'(pass), 32'd1);

        // start and table write while busy are ignored.
        test_value = 16'h0000;
        do_start(3);
        drive(16'h0005);
        start       = 1'b1;
        exp_count   = 5'd1;
        exp_wr_en   = 1'b1;
        exp_wr_addr = 4'd1;
        exp_wr_data = 16'hBEEF;
        @(negedge clk);
        start     = 1'b0;
        exp_wr_en = 1'b0;
        chk("t7_busy", 32'(busy), 32'd1);
        drive(16'h000A);
        drive(16'h000F);
        chk("t7_pass", 32'(pass), 32'd1);
        chk("t7_mis", 32'(mismatch_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
